// File: rtl/fp_pkg.sv
// ============================================================================
// fp_pkg : shared binary32 constants, operand classification, divider states
// Rev 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_DIVIDE = 2'd1,
        DIV_ROUND  = 2'd2,
        DIV_DONE   = 2'd3
    } div_state_t;

    // Subnormals (exp=0, frac!=0) deliberately classify as zero.
    function automatic fp_class_t classify(input logic [7:0] exp, input logic [22:0] frac);
        fp_class_t c;
        c.zero = (exp == 8'h00);
        c.inf  = (exp == 8'hFF) && (frac == 23'd0);
        c.nan  = (exp == 8'hFF) && (frac != 23'd0);
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mant_div_step.sv
// ============================================================================
// mant_div_step : one combinational restoring-division iteration
// Rev 1.0
// ============================================================================
`default_nettype none

module mant_div_step (
    input  logic [24:0] rem,
    input  logic [23:0] divisor,
    output logic        qbit,
    output logic [24:0] rem_next
);

    logic [24:0] w_diff;

    // rem < 2*divisor always holds, so the shifted difference fits in 25 bits.
    always_comb begin
        qbit     = (rem >= {1'b0, divisor});
        w_diff   = qbit ? (rem - {1'b0, divisor}) : rem;
        rem_next = w_diff << 1;
    end

endmodule

`default_nettype wire

// File: rtl/division.sv
// ============================================================================
// division : multi-cycle binary32 divider, 26-step restoring core, RNE rounding
// Rev 1.0
// ============================================================================
`default_nettype none

module division
    import fp_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);

    div_state_t         r_state;
    logic [24:0]        r_rem;
    logic [23:0]        r_div;
    logic [25:0]        r_quo;
    logic [4:0]         r_count;
    logic signed [9:0]  r_exp;
    logic               r_sign;
    logic [31:0]        r_result;
    logic               r_done;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_div_by_zero;
    logic               r_invalid;

    fp32_t              w_a;
    fp32_t              w_b;
    fp_class_t          w_ca;
    fp_class_t          w_cb;
    logic               w_sign;
    logic               w_special;
    logic [31:0]        w_spec_res;
    logic [3:0]         w_spec_flags;
    logic signed [9:0]  w_exp_init;

    logic               w_qbit;
    logic [24:0]        w_rem_next;

    logic [22:0]        w_frac_pre;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic               w_carry;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_exp_adj;
    logic signed [9:0]  w_exp_fin;

    assign w_a        = data1;
    assign w_b        = data2;
    assign w_ca       = classify(w_a.exp, w_a.frac);
    assign w_cb       = classify(w_b.exp, w_b.frac);
    assign w_sign     = w_a.sign ^ w_b.sign;
    assign w_exp_init = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp}) + 10'(BIAS);

    // Flags packed as {overflow, underflow, div_by_zero, invalid}.
    always_comb begin
        w_special    = 1'b1;
        w_spec_res   = QNAN;
        w_spec_flags = 4'b0001;
        if (w_ca.nan || w_cb.nan) begin
            w_spec_res   = QNAN;
            w_spec_flags = 4'b0001;
        end else if ((w_ca.zero && w_cb.zero) || (w_ca.inf && w_cb.inf)) begin
            w_spec_res   = QNAN;
            w_spec_flags = 4'b0001;
        end else if (!w_ca.inf && w_cb.zero) begin
            w_spec_res   = POS_INF | {w_sign, 31'd0};
            w_spec_flags = 4'b0010;
        end else if (w_ca.inf) begin
            w_spec_res   = POS_INF | {w_sign, 31'd0};
            w_spec_flags = 4'b0000;
        end else if (w_ca.zero || w_cb.inf) begin
            w_spec_res   = {w_sign, 31'd0};
            w_spec_flags = 4'b0000;
        end else begin
            w_special    = 1'b0;
            w_spec_res   = 32'd0;
            w_spec_flags = 4'b0000;
        end
    end

    mant_div_step u_step (
        .rem      (r_rem),
        .divisor  (r_div),
        .qbit     (w_qbit),
        .rem_next (w_rem_next)
    );

    // Normalise the 26-bit quotient, then round to nearest-even.
    always_comb begin
        if (r_quo[25]) begin
            w_frac_pre = r_quo[24:2];
            w_guard    = r_quo[1];
            w_sticky   = r_quo[0] | (|r_rem);
            w_exp_adj  = r_exp;
        end else begin
            w_frac_pre = r_quo[23:1];
            w_guard    = r_quo[0];
            w_sticky   = |r_rem;
            w_exp_adj  = r_exp - 10'sd1;
        end
        w_round_up = w_guard & (w_sticky | w_frac_pre[0]);
        w_carry    = w_round_up & (&w_frac_pre);
        w_frac     = w_frac_pre + {22'd0, w_round_up};
        w_exp_fin  = w_carry ? (w_exp_adj + 10'sd1) : w_exp_adj;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state       <= DIV_IDLE;
            r_rem         <= '0;
            r_div         <= '0;
            r_quo         <= '0;
            r_count       <= '0;
            r_exp         <= '0;
            r_sign        <= 1'b0;
            r_result      <= '0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_invalid     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        if (w_special) begin
                            r_result      <= w_spec_res;
                            r_overflow    <= w_spec_flags[3];
                            r_underflow   <= w_spec_flags[2];
                            r_div_by_zero <= w_spec_flags[1];
                            r_invalid     <= w_spec_flags[0];
                            r_done        <= 1'b1;
                            r_state       <= DIV_DONE;
                        end else begin
                            r_rem   <= {2'b01, w_a.frac};
                            r_div   <= {1'b1, w_b.frac};
                            r_quo   <= '0;
                            r_count <= '0;
                            r_exp   <= w_exp_init;
                            r_sign  <= w_sign;
                            r_state <= DIV_DIVIDE;
                        end
                    end
                end
                DIV_DIVIDE: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= {r_quo[24:0], w_qbit};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd25) begin
                        r_state <= DIV_ROUND;
                    end
                end
                DIV_ROUND: begin
                    r_div_by_zero <= 1'b0;
                    r_invalid     <= 1'b0;
                    if (w_exp_fin >= 10'sd255) begin
                        r_result    <= POS_INF | {r_sign, 31'd0};
                        r_overflow  <= 1'b1;
                        r_underflow <= 1'b0;
                    end else if (w_exp_fin <= 10'sd0) begin
                        r_result    <= {r_sign, 31'd0};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b1;
                    end else begin
                        r_result    <= {r_sign, w_exp_fin[7:0], w_frac};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign ready       = (r_state == DIV_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign div_by_zero = r_div_by_zero;
    assign invalid     = r_invalid;

endmodule

`default_nettype wire

// File: tb/tb_division.sv
// ============================================================================
// tb_division : self-checking bench for the binary32 divider
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_division;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;

    int checks = 0;
    int failures = 0;

    division dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .start       (start),
        .data1       (data1),
        .data2       (data2),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    always #5 CLK = ~CLK;

    localparam int NDIR = 13;
    localparam logic [31:0] DA [NDIR] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h3F800000,
        32'h00000000, 32'h7FC00001, 32'h7F000000, 32'h00800000, 32'hFF800000, 32'h80000000,
        32'h00000001, 32'h7F800000, 32'h3F800000};
    localparam logic [31:0] DB [NDIR] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000,
        32'h00000000, 32'h3F800000, 32'h3E800000, 32'h40000000, 32'h00000000, 32'h7F800000,
        32'hBF800000, 32'hFF800000, 32'h3F800000};
    localparam logic [31:0] DR [NDIR] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000, 32'h7F800000,
        32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'hFF800000, 32'h80000000,
        32'h80000000, 32'h7FC00000, 32'h3F800000};
    // {overflow, underflow, div_by_zero, invalid}
    localparam logic [3:0] DF [NDIR] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0001,
        4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    localparam int DL [NDIR] = '{28, 28, 28, 1, 1, 1, 28, 28, 1, 1, 1, 1, 28};

    // Reference: exact integer quotient with true round-to-nearest-even on the remainder.
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic s, za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, num, q, r;
        int e;
        s  = a[31] ^ b[31];
        za = (a[30:23] == 8'h00);
        zb = (b[30:23] == 8'h00);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (na || nb) return {32'h7FC00000, 4'b0001};
        if ((za && zb) || (ia && ib)) return {32'h7FC00000, 4'b0001};
        if (!ia && zb) return {s, 8'hFF, 23'd0, 4'b0010};
        if (ia) return {s, 8'hFF, 23'd0, 4'b0000};
        if (za || ib) return {s, 31'd0, 4'b0000};
        ma = 64'h800000 | 64'(a[22:0]);
        mb = 64'h800000 | 64'(b[22:0]);
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (ma >= mb) begin
            num = ma << 23;
        end else begin
            num = ma << 24;
            e   = e - 1;
        end
        q = num / mb;
        r = num % mb;
        if ((2 * r > mb) || ((2 * r == mb) && (q % 2 == 1))) q = q + 1;
        if (q == 64'h1000000) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 4'b1000};
        if (e <= 0) return {s, 31'd0, 4'b0100};
        return {s, 8'(e), q[22:0], 4'b0000};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] sp [6] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                32'h7FC00000, 32'h00000001};
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return $urandom;
        if (sel == 1) return sp[$urandom_range(0, 5)];
        return {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
    endfunction

    // Drives one request, then waits (bounded) for done; latency counts edges after accept.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                          output logic [3:0] fl, output int lat, output logic post_done,
                          output logic post_ready);
        @(negedge CLK);
        start = 1'b1;
        data1 = a;
        data2 = b;
        @(negedge CLK);
        start = 1'b0;
        data1 = $urandom;
        data2 = $urandom;
        lat = 1;
        while (lat <= 40 && !done) begin
            @(negedge CLK);
            lat++;
        end
        res = result;
        fl  = {overflow, underflow, div_by_zero, invalid};
        @(negedge CLK);
        post_done  = done;
        post_ready = ready;
    endtask

    task automatic test_reset();
        nRST  = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b done=%b, expected ready=1 done=0", ready, done);
        end
        checks++;
        if (result !== 32'd0 || {overflow, underflow, div_by_zero, invalid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_data: result=%h flags=%b, expected 00000000 0000", result,
                     {overflow, underflow, div_by_zero, invalid});
        end
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b done=%b, expected 1 0", ready, done);
        end
    endtask

    task automatic test_directed();
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        logic        pd, pr;
        for (int i = 0; i < NDIR; i++) begin
            checks++;
            if (ready !== 1'b1) begin
                failures++;
                $display("FAIL dir_ready[%0d]: ready=%b, expected 1", i, ready);
            end
            run_op(DA[i], DB[i], res, fl, lat, pd, pr);
            checks++;
            if (res !== DR[i]) begin
                failures++;
                $display("FAIL dir_result[%0d] %h/%h: got %h, expected %h", i, DA[i], DB[i], res, DR[i]);
            end
            checks++;
            if (fl !== DF[i]) begin
                failures++;
                $display("FAIL dir_flags[%0d]: got %b, expected %b", i, fl, DF[i]);
            end
            checks++;
            if (lat !== DL[i]) begin
                failures++;
                $display("FAIL dir_latency[%0d]: got %0d, expected %0d", i, lat, DL[i]);
            end
            checks++;
            if (pd !== 1'b0 || pr !== 1'b1) begin
                failures++;
                $display("FAIL dir_pulse[%0d]: done=%b ready=%b after pulse, expected 0 1", i, pd, pr);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res;
        logic [3:0]  fl;
        logic [35:0] exp_v;
        int          lat, exp_lat;
        logic        pd, pr;
        for (int i = 0; i < 250; i++) begin
            a = rand_op();
            b = rand_op();
            exp_v = ref_div(a, b);
            exp_lat = (a[30:23] != 8'h00 && a[30:23] != 8'hFF &&
                       b[30:23] != 8'h00 && b[30:23] != 8'hFF) ? 28 : 1;
            run_op(a, b, res, fl, lat, pd, pr);
            checks++;
            if (res !== exp_v[35:4] || fl !== exp_v[3:0]) begin
                failures++;
                $display("FAIL rand_result %h/%h: got %h flags %b, expected %h flags %b",
                         a, b, res, fl, exp_v[35:4], exp_v[3:0]);
            end
            checks++;
            if (lat !== exp_lat || pd !== 1'b0) begin
                failures++;
                $display("FAIL rand_timing %h/%h: latency %0d done_after=%b, expected %0d 0",
                         a, b, lat, pd, exp_lat);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int          dcnt = 0;
        int          dn = -1;
        logic [31:0] res = '0;
        logic        busy_ready = 1'b1;
        @(negedge CLK);
        start = 1'b1;
        data1 = 32'h40C00000;
        data2 = 32'h40000000;
        for (int n = 1; n <= 70; n++) begin
            @(negedge CLK);
            if (done) begin
                dcnt++;
                dn  = n;
                res = result;
            end
            if (n == 3) busy_ready = ready;
            start = (n == 3 || n == 10);
            data1 = $urandom;
            data2 = $urandom;
        end
        start = 1'b0;
        checks++;
        if (busy_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready: ready=%b while dividing, expected 0", busy_ready);
        end
        checks++;
        if (dcnt != 1 || dn != 28) begin
            failures++;
            $display("FAIL busy_done: %0d pulses, last at +%0d, expected 1 at +28", dcnt, dn);
        end
        checks++;
        if (res !== 32'h40400000) begin
            failures++;
            $display("FAIL busy_result: got %h, expected 40400000", res);
        end
    endtask

    task automatic test_abort();
        int          dcnt = 0;
        logic        rdy11 = 1'b0;
        logic [31:0] res11 = 32'hFFFFFFFF;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        logic        pd, pr;
        @(negedge CLK);
        start = 1'b1;
        data1 = 32'h3F800000;
        data2 = 32'h40400000;
        for (int n = 1; n <= 45; n++) begin
            @(negedge CLK);
            if (done) dcnt++;
            if (n == 11) begin
                rdy11 = ready;
                res11 = result;
            end
            start = 1'b0;
            nRST  = (n == 10) ? 1'b0 : 1'b1;
        end
        checks++;
        if (rdy11 !== 1'b1 || res11 !== 32'd0) begin
            failures++;
            $display("FAIL abort_state: ready=%b result=%h after reset, expected 1 00000000", rdy11, res11);
        end
        checks++;
        if (dcnt != 0) begin
            failures++;
            $display("FAIL abort_done: %0d done pulses, expected 0", dcnt);
        end
        run_op(32'h40C00000, 32'h40000000, res, fl, lat, pd, pr);
        checks++;
        if (res !== 32'h40400000 || fl !== 4'b0000 || lat != 28) begin
            failures++;
            $display("FAIL abort_recover: got %h flags %b latency %0d, expected 40400000 0000 28",
                     res, fl, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
